// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
//   pll_seq_state_e : 2-bit sequencer state, encodings visible on the debug port
//   DEF_*           : default parameter values
//   cnt_width()     : counter width for a terminal count (clog2, at least 1 bit)
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK    = 2'd0,
    STABILIZE    = 2'd1,
    RELEASE_CORE = 2'd2,
    RUN          = 2'd3
  } pll_seq_state_e;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_STAGE_GAP_CYCLES   = 16;
  localparam int unsigned DEF_LOSS_CNT_WIDTH     = 8;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? int'($clog2(limit)) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// N-stage flop chain for bringing a single asynchronous flag into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input flag
//   q     : synchronized flag (last stage)
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies the PLL locked flag and releases staged resets (core, then
// peripheral), tracking lock-loss events for status readout.
//   clock        : PLL output clock
//   reset_n      : asynchronous active-low reset
//   locked       : PLL lock flag, asynchronous
//   clear_status : pulse, clears lock_lost and loss_count
//   core_rst_n   : active-low core reset
//   periph_rst_n : active-low peripheral/readout reset
//   ready        : high in RUN
//   lock_lost    : sticky lock-loss flag
//   loss_count   : saturating lock-loss count
//   state        : current sequencer state (debug)
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned LOSS_CNT_WIDTH     = DEF_LOSS_CNT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      locked,
  input  logic                      clear_status,
  output logic                      core_rst_n,
  output logic                      periph_rst_n,
  output logic                      ready,
  output logic                      lock_lost,
  output logic [LOSS_CNT_WIDTH-1:0] loss_count,
  output logic [1:0]                state
);

  localparam int unsigned STAB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned GAP_W  = cnt_width(STAGE_GAP_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);

  logic lock_s;

  // One retiming flop sits between the synchronizer and the FSM: with it,
  // core release lands SYNC_STAGES + LOCK_STABLE_CYCLES + 1 edges after the
  // first locked sample, and a loss drops the resets SYNC_STAGES + 1 edges
  // after it is first sampled.
  logic lock_q, lock_d;

  pll_seq_state_e state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              loss;

  logic                      core_rst_n_q, core_rst_n_d;
  logic                      periph_rst_n_q, periph_rst_n_d;
  logic                      ready_q, ready_d;
  logic                      lock_lost_q, lock_lost_d;
  logic [LOSS_CNT_WIDTH-1:0] loss_count_q, loss_count_d;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clock),
    .rst_n(reset_n),
    .d    (locked),
    .q    (lock_s)
  );

  // State and output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q         <= 1'b0;
      state_q        <= WAIT_LOCK;
      stab_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      core_rst_n_q   <= 1'b0;
      periph_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      loss_count_q   <= '0;
    end else begin
      lock_q         <= lock_d;
      state_q        <= state_d;
      stab_cnt_q     <= stab_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      core_rst_n_q   <= core_rst_n_d;
      periph_rst_n_q <= periph_rst_n_d;
      ready_q        <= ready_d;
      lock_lost_q    <= lock_lost_d;
      loss_count_q   <= loss_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    lock_d     = lock_s;
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    loss       = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        stab_cnt_d = '0;
        if (lock_q) begin
          state_d = STABILIZE;
        end
      end
      STABILIZE: begin
        // A dropout here only restarts qualification; it is not a loss.
        if (!lock_q) begin
          state_d = WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d   = RELEASE_CORE;
          gap_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RELEASE_CORE: begin
        if (!lock_q) begin
          state_d = WAIT_LOCK;
          loss    = 1'b1;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = RUN;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_q) begin
          state_d = WAIT_LOCK;
          loss    = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output logic: decoded from the next state so outputs move on the same
  // edge as the state; status applies clear first so a coincident loss wins.
  always_comb begin
    core_rst_n_d   = (state_d == RELEASE_CORE) || (state_d == RUN);
    periph_rst_n_d = (state_d == RUN);
    ready_d        = (state_d == RUN);
    lock_lost_d    = lock_lost_q;
    loss_count_d   = loss_count_q;
    if (clear_status) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
    end
    if (loss) begin
      lock_lost_d = 1'b1;
      if (loss_count_d != '1) begin
        loss_count_d = loss_count_d + 1'b1;
      end
    end
  end

  assign core_rst_n   = core_rst_n_q;
  assign periph_rst_n = periph_rst_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign loss_count   = loss_count_q;
  assign state        = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sits directly downstream of the 48→140 MHz PLL and runs in the 140 MHz output domain. It consumes the PLL's asynchronous `locked` flag, qualifies it as stable, and releases two staged synchronous resets: core logic first, then peripheral/readout logic. It also records lock-loss events for the ESP32 status path.

## Interface
- `SYNC_STAGES`, 2: flops in the `locked` synchronizer, ≥2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before core reset release, ≥1.
- `STAGE_GAP_CYCLES`, 16: cycles between core release and peripheral release, ≥1.
- `LOSS_CNT_WIDTH`, 8: width of the saturating lock-loss counter, ≥1.

Ports:
- `clock` in 1: PLL output clock, 140 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock flag, asynchronous to `clock`.
- `clear_status` in 1: single-cycle pulse; clears `loss_count` and `lock_lost`.
- `core_rst_n` out 1: active-low reset for core logic.
- `periph_rst_n` out 1: active-low reset for peripheral/readout logic.
- `ready` out 1: high when in RUN.
- `lock_lost` out 1: sticky; set on any lock loss after core release.
- `loss_count` out LOSS_CNT_WIDTH: saturating count of lock losses.
- `state` out 2: current FSM state, for debug.

## Operation
- Reset values: `core_rst_n`=0, `periph_rst_n`=0, `ready`=0, `lock_lost`=0, `loss_count`=0, `state`=WAIT_LOCK.
- `reset_n` assertion forces all outputs to their reset values asynchronously. Deassertion takes effect at the next `clock` edge.
- `locked` passes through a SYNC_STAGES synchronizer to give `lock_s`. The FSM uses only `lock_s`.
- FSM states and encodings:
  - WAIT_LOCK (0): both resets asserted. Moves to STABILIZE when `lock_s`=1; the stable counter is cleared.
  - STABILIZE (1): the counter increments each cycle while `lock_s`=1. When the counter reaches LOCK_STABLE_CYCLES-1 with `lock_s`=1, moves to RELEASE_CORE. If `lock_s`=0, returns to WAIT_LOCK; this is not counted as a loss.
  - RELEASE_CORE (2): `core_rst_n`=1. The gap counter runs for STAGE_GAP_CYCLES cycles, then moves to RUN.
  - RUN (3): `core_rst_n`=`periph_rst_n`=`ready`=1.
- Lock loss is `lock_s`=0 while in RELEASE_CORE or RUN. On loss:
  - Next state is WAIT_LOCK, and all three outputs go low on the same edge.
  - `lock_lost` is set.
  - `loss_count` increments and saturates at all-ones.
- `clear_status` zeroes `lock_lost` and `loss_count`. If a loss occurs in the same cycle, the loss wins: `loss_count`=1, `lock_lost`=1.
- After a loss, relock re-runs the full STABILIZE and RELEASE_CORE sequence. There is no shortcut.
- All outputs are registered; nothing is driven combinationally from `locked`.

## Timing
- Let cycle 0 be the first edge at which `locked`=1 is sampled by synchronizer stage 1, with `locked` staying high:
  - `core_rst_n` rises at cycle SYNC_STAGES + LOCK_STABLE_CYCLES + 1.
  - `periph_rst_n` and `ready` rise STAGE_GAP_CYCLES cycles later.
- A lock loss first sampled at cycle L drops `core_rst_n`, `periph_rst_n` and `ready` at cycle L + SYNC_STAGES + 1. `loss_count` and `lock_lost` update on the same edge.
- A `locked` dropout of any length that reaches `lock_s` during STABILIZE restarts qualification from WAIT_LOCK.
- `clear_status` takes effect on the next edge, with a latency of 1 cycle.
- Counter widths are $clog2 of each limit, minimum 1 bit. No counter wraps.

## Structure
- Package `pll_seq_pkg`:
  - 2-bit state typedef with the WAIT_LOCK/STABILIZE/RELEASE_CORE/RUN encodings above.
  - Default parameter constants.
- One sub-module: `bit_synchronizer`, an N-stage flop chain with a parameterised depth and asynchronous active-low reset to 0. It is reused elsewhere in the design for other asynchronous flags.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, LOSS_CNT_WIDTH=2.
- Clean startup: release reset, then `locked`=1 sampled at cycle 0 → `core_rst_n` rises at cycle 11; `periph_rst_n` and `ready` rise at cycle 15; `loss_count`=0.
- Glitch during STABILIZE: `locked` low for 1 cycle at cycle 6 → returns to WAIT_LOCK; `core_rst_n` release is delayed by the full 8-cycle requalification; `lock_lost`=0, `loss_count`=0.
- Loss in RUN: `locked` falls, sampled at cycle L → all three outputs low at L+3; `state`=0; `lock_lost`=1; `loss_count`=1. Relock repeats the 11/15-cycle sequence.
- Saturation: 5 loss/relock cycles → `loss_count`=3 and stays at 3.
- Clear collision: `clear_status` on the same edge as a loss → `loss_count`=1, `lock_lost`=1. A later lone `clear_status` → both 0 one cycle later.
- Mid-run reset: `reset_n` low in RUN → all outputs at reset values before the next `clock` edge; `state`=WAIT_LOCK.
